// File: rtl/doppler_sequencer.sv
// Pulse-repetition controller: shadow config bank with validated commits, and
// an ENABLE sequencer for single, continuous or free-running pulse frames.
module doppler_sequencer #(
   parameter logic [15:0] DEF_S0   = 16'd32,
   parameter logic [15:0] DEF_S1   = 16'd64,
   parameter logic [15:0] DEF_S2   = 16'd1024,
   parameter logic [15:0] DEF_SR   = 16'd4096,
   parameter logic [1:0]  DEF_FREQ = 2'b00
) (
   input  logic        coreClock,
   input  logic        RESET,
   input  logic        wrEn,
   input  logic [2:0]  wrAddr,
   input  logic [15:0] wrData,
   input  logic        start,
   input  logic        stop,
   input  logic        RETRANSMIT,
   output logic        ENABLE,
   output logic [1:0]  freq,
   output logic [15:0] State0Value,
   output logic [15:0] State1Value,
   output logic [15:0] State2Value,
   output logic [15:0] StateRValue,
   output logic [15:0] pulseCount,
   output logic        busy,
   output logic        frameDone,
   output logic        cfgPending,
   output logic        cfgError
);
   localparam int unsigned DW = 16;
   localparam int unsigned FW = 2;
   localparam logic [2:0] A_S0 = 3'd0, A_S1 = 3'd1, A_S2 = 3'd2, A_SR = 3'd3;
   localparam logic [2:0] A_N = 3'd4, A_MODE = 3'd5, A_COMMIT = 3'd6;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic          en_q, en_d, busy_q, busy_d, fd_q, fd_d;

   logic [DW-1:0] sh_s0_q, sh_s1_q, sh_s2_q, sh_sr_q, sh_n_q;
   logic [DW-1:0] sh_s0_d, sh_s1_d, sh_s2_d, sh_sr_d, sh_n_d;
   logic [FW-1:0] sh_freq_q, sh_freq_d;
   logic          sh_cont_q, sh_cont_d;

   logic [DW-1:0] s0_q, s1_q, s2_q, sr_q, n_q;
   logic [DW-1:0] s0_d, s1_d, s2_d, sr_d, n_d;
   logic [FW-1:0] freq_q, freq_d;
   logic          cont_q, cont_d;
   logic          pend_q, pend_d, err_q, err_d;

   logic          commit_wr, apply, cfg_ok, last_pulse;

   // Host writes into the shadow bank
   always_comb begin
      sh_s0_d   = sh_s0_q;
      sh_s1_d   = sh_s1_q;
      sh_s2_d   = sh_s2_q;
      sh_sr_d   = sh_sr_q;
      sh_n_d    = sh_n_q;
      sh_freq_d = sh_freq_q;
      sh_cont_d = sh_cont_q;
      if (wrEn) begin
         case (wrAddr)
            A_S0:   sh_s0_d = wrData;
            A_S1:   sh_s1_d = wrData;
            A_S2:   sh_s2_d = wrData;
            A_SR:   sh_sr_d = wrData;
            A_N:    sh_n_d  = wrData;
            A_MODE: begin
               sh_freq_d = wrData[1:0];
               sh_cont_d = wrData[2];
            end
            default: ;
         endcase
      end
   end

   // Commit handling: apply only in IDLE or on a pulse boundary
   always_comb begin
      commit_wr = wrEn && (wrAddr == A_COMMIT);
      apply     = pend_q && ((state_q == IDLE) || RETRANSMIT);
      cfg_ok    = (sh_s0_q != '0) && (sh_s0_q < sh_s1_q) &&
                  (sh_s1_q < sh_s2_q) && (sh_s2_q < sh_sr_q);
      s0_d   = s0_q;
      s1_d   = s1_q;
      s2_d   = s2_q;
      sr_d   = sr_q;
      n_d    = n_q;
      freq_d = freq_q;
      cont_d = cont_q;
      err_d  = err_q;
      if (apply) begin
         err_d = !cfg_ok;
         if (cfg_ok) begin
            s0_d   = sh_s0_q;
            s1_d   = sh_s1_q;
            s2_d   = sh_s2_q;
            sr_d   = sh_sr_q;
            n_d    = sh_n_q;
            freq_d = sh_freq_q;
            cont_d = sh_cont_q;
         end
      end
      pend_d = (pend_q && !apply) || commit_wr;
   end

   // State register
   always_ff @(posedge coreClock or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and pulse counter
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      last_pulse = (n_q != '0) && (pc_q == n_q - DW'(1));
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               pc_d    = '0;
            end
         end
         RUN: begin
            if (RETRANSMIT) pc_d = pc_q + DW'(1);
            if (stop)                           state_d = DRAIN;
            else if (RETRANSMIT && last_pulse)  state_d = DONE;
         end
         DRAIN: begin
            if (RETRANSMIT) begin
               pc_d    = pc_q + DW'(1);
               state_d = IDLE;
            end
         end
         DONE: begin
            if (stop || !cont_q) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
               pc_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs follow the state being entered
   always_comb begin
      en_d   = (state_d == RUN) || (state_d == DRAIN);
      busy_d = (state_d != IDLE);
      fd_d   = (state_d == DONE);
   end

   always_ff @(posedge coreClock or posedge RESET) begin
      if (RESET) begin
         pc_q      <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         fd_q      <= 1'b0;
         sh_s0_q   <= DEF_S0;
         sh_s1_q   <= DEF_S1;
         sh_s2_q   <= DEF_S2;
         sh_sr_q   <= DEF_SR;
         sh_n_q    <= '0;
         sh_freq_q <= DEF_FREQ;
         sh_cont_q <= 1'b0;
         s0_q      <= DEF_S0;
         s1_q      <= DEF_S1;
         s2_q      <= DEF_S2;
         sr_q      <= DEF_SR;
         n_q       <= '0;
         freq_q    <= DEF_FREQ;
         cont_q    <= 1'b0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         fd_q      <= fd_d;
         sh_s0_q   <= sh_s0_d;
         sh_s1_q   <= sh_s1_d;
         sh_s2_q   <= sh_s2_d;
         sh_sr_q   <= sh_sr_d;
         sh_n_q    <= sh_n_d;
         sh_freq_q <= sh_freq_d;
         sh_cont_q <= sh_cont_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         sr_q      <= sr_d;
         n_q       <= n_d;
         freq_q    <= freq_d;
         cont_q    <= cont_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
      end
   end

   assign ENABLE      = en_q;
   assign busy        = busy_q;
   assign frameDone   = fd_q;
   assign pulseCount  = pc_q;
   assign freq        = freq_q;
   assign State0Value = s0_q;
   assign State1Value = s1_q;
   assign State2Value = s2_q;
   assign StateRValue = sr_q;
   assign cfgPending  = pend_q;
   assign cfgError    = err_q;
endmodule

// File: tb/tb_doppler_sequencer.sv
// Scoreboard bench for doppler_sequencer: a behavioural model pushes the
// expected outputs for every driven cycle; they are popped and compared after the edge.
module tb_doppler_sequencer;
   logic        coreClock = 1'b0;
   logic        RESET = 1'b1;
   logic        wrEn = 1'b0;
   logic [2:0]  wrAddr = '0;
   logic [15:0] wrData = '0;
   logic        start = 1'b0, stop = 1'b0, RETRANSMIT = 1'b0;
   logic        ENABLE, busy, frameDone, cfgPending, cfgError;
   logic [1:0]  freq;
   logic [15:0] State0Value, State1Value, State2Value, StateRValue, pulseCount;

   doppler_sequencer dut (
      .coreClock(coreClock), .RESET(RESET), .wrEn(wrEn), .wrAddr(wrAddr),
      .wrData(wrData), .start(start), .stop(stop), .RETRANSMIT(RETRANSMIT),
      .ENABLE(ENABLE), .freq(freq), .State0Value(State0Value),
      .State1Value(State1Value), .State2Value(State2Value),
      .StateRValue(StateRValue), .pulseCount(pulseCount), .busy(busy),
      .frameDone(frameDone), .cfgPending(cfgPending), .cfgError(cfgError)
   );

   always #5 coreClock = ~coreClock;

   typedef struct packed {
      logic        en;
      logic [1:0]  fq;
      logic [15:0] s0, s1, s2, sr, pc;
      logic        busy, fd, pend, err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
   int          m_st;
   logic [15:0] m_pc, m_sh [4], m_act [4], m_shn, m_n;
   logic [1:0]  m_shf, m_f;
   logic        m_shc, m_c, m_pend, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_pc = 0; m_pend = 0; m_err = 0;
      m_sh[0] = 32; m_sh[1] = 64; m_sh[2] = 1024; m_sh[3] = 4096;
      m_act = m_sh; m_shn = 0; m_n = 0; m_shf = 0; m_f = 0; m_shc = 0; m_c = 0;
   endtask

   task automatic model_next();
      bit commit, apply, ok;
      int nst;
      commit = wrEn && (wrAddr == 3'd6);
      apply  = m_pend && ((m_st == M_IDLE) || RETRANSMIT);
      ok     = (m_sh[0] > 0) && (m_sh[0] < m_sh[1]) && (m_sh[1] < m_sh[2]) && (m_sh[2] < m_sh[3]);
      nst = m_st;
      case (m_st)
         M_IDLE: if (start && !stop) begin nst = M_RUN; m_pc = 0; end
         M_RUN: begin
            if (RETRANSMIT) begin
               m_pc = 16'(m_pc + 1);
               if (m_n != 0 && m_pc == m_n) nst = M_DONE;
            end
            if (stop) nst = M_DRAIN;
         end
         M_DRAIN: if (RETRANSMIT) begin m_pc = 16'(m_pc + 1); nst = M_IDLE; end
         default: begin
            if (stop || !m_c) nst = M_IDLE;
            else begin nst = M_RUN; m_pc = 0; end
         end
      endcase
      m_st = nst;
      if (apply) begin
         if (ok) begin
            m_act = m_sh; m_n = m_shn; m_f = m_shf; m_c = m_shc; m_err = 0;
         end else m_err = 1;
      end
      m_pend = (m_pend && !apply) || commit;
      if (wrEn) begin
         if (wrAddr < 4) m_sh[wrAddr[1:0]] = wrData;
         else if (wrAddr == 4) m_shn = wrData;
         else if (wrAddr == 5) begin m_shf = wrData[1:0]; m_shc = wrData[2]; end
      end
   endtask

   // Drive one cycle: predict, push, clock, pop and compare
   task automatic step();
      exp_t e;
      if (RESET) model_reset();
      else model_next();
      e.en = (m_st == M_RUN) || (m_st == M_DRAIN);
      e.fq = m_f;
      e.s0 = m_act[0]; e.s1 = m_act[1]; e.s2 = m_act[2]; e.sr = m_act[3];
      e.pc = m_pc;
      e.busy = (m_st != M_IDLE);
      e.fd = (m_st == M_DONE);
      e.pend = m_pend; e.err = m_err;
      sb.push_back(e);
      @(posedge coreClock); #1;
      e = sb.pop_front();
      chk("enable", ENABLE, e.en);
      chk("freq", freq, e.fq);
      chk("s0", State0Value, e.s0);
      chk("s1", State1Value, e.s1);
      chk("s2", State2Value, e.s2);
      chk("sr", StateRValue, e.sr);
      chk("pulse_count", pulseCount, e.pc);
      chk("busy", busy, e.busy);
      chk("frame_done", frameDone, e.fd);
      chk("cfg_pending", cfgPending, e.pend);
      chk("cfg_error", cfgError, e.err);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      wrEn = 1; wrAddr = a; wrData = d;
      step();
      wrEn = 0;
   endtask

   task automatic pulse(input int gap);
      repeat (gap) step();
      RETRANSMIT = 1;
      step();
      RETRANSMIT = 0;
   endtask

   initial begin
      model_reset();
      step(); step();
      chk("rst_enable", ENABLE, 0);
      chk("rst_s0", State0Value, 32);
      chk("rst_s2", State2Value, 1024);
      chk("rst_sr", StateRValue, 4096);
      RESET = 0;

      // IDLE commit takes effect one edge after the commit write
      wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
      wr(6, 0);
      chk("idle_commit_pend", cfgPending, 1);
      chk("idle_commit_old", State0Value, 32);
      step();
      chk("idle_commit_s0", State0Value, 10);
      chk("idle_commit_sr", StateRValue, 40);
      chk("idle_commit_clr", cfgPending, 0);

      // Single frame of 3 pulses
      wr(4, 3); wr(5, 0); wr(6, 0); step();
      start = 1; step(); start = 0;
      chk("single_run_en", ENABLE, 1);
      pulse(2); pulse(2); pulse(2);
      chk("single_done_fd", frameDone, 1);
      chk("single_done_en", ENABLE, 0);
      chk("single_done_pc", pulseCount, 3);
      step();
      chk("single_idle", busy, 0);

      // Continuous frames of 2, stop during DONE
      wr(4, 2); wr(5, 16'h0006); wr(6, 0); step();
      chk("cont_freq", freq, 2);
      start = 1; step(); start = 0;
      pulse(1); pulse(1);
      chk("cont_done_fd", frameDone, 1);
      step();
      chk("cont_resume_en", ENABLE, 1);
      chk("cont_resume_pc", pulseCount, 0);
      pulse(1); pulse(1);
      stop = 1; step(); stop = 0;
      chk("cont_stop_idle", busy, 0);

      // Free-run: commit mid-pulse waits for RETRANSMIT, then drain on stop
      wr(4, 0); wr(5, 0); wr(6, 0); step();
      start = 1; step(); start = 0;
      pulse(2);
      wr(3, 1000); wr(2, 500); wr(6, 0); step(); step();
      chk("midpulse_s2_hold", State2Value, 30);
      chk("midpulse_pend", cfgPending, 1);
      RETRANSMIT = 1; step(); RETRANSMIT = 0;
      chk("midpulse_s2_new", State2Value, 500);
      chk("midpulse_pc", pulseCount, 2);
      stop = 1; step(); step();
      chk("drain_en", ENABLE, 1);
      stop = 0;
      pulse(1);
      chk("drain_idle", busy, 0);
      chk("drain_pc", pulseCount, 3);

      // Invalid then valid commit
      wr(0, 50); wr(1, 50); wr(6, 0); step();
      chk("bad_err", cfgError, 1);
      chk("bad_s0_kept", State0Value, 10);
      wr(1, 60); wr(6, 0); step();
      chk("good_err", cfgError, 0);
      chk("good_s1", State1Value, 60);

      // N=1 with stop and RETRANSMIT together takes the drain path
      wr(4, 1); wr(6, 0); step();
      start = 1; step(); start = 0;
      stop = 1; RETRANSMIT = 1; step(); stop = 0; RETRANSMIT = 0;
      chk("n1_stop_fd", frameDone, 0);
      chk("n1_stop_en", ENABLE, 1);
      pulse(1);
      chk("n1_idle", busy, 0);
      chk("n1_pc", pulseCount, 2);
      start = 1; stop = 1; step(); step(); start = 0; stop = 0;
      chk("start_stop_idle", busy, 0);

      // Commit write on the apply edge re-arms pending
      wr(6, 0); wr(6, 0);
      chk("rearm_pend", cfgPending, 1);
      step();
      chk("rearm_clr", cfgPending, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         wrEn = ($urandom_range(0, 7) == 0);
         wrAddr = 3'($urandom_range(0, 7));
         if (wrAddr < 4) wrData = 16'($urandom_range(wrAddr * 300, wrAddr * 300 + 320));
         else if (wrAddr == 4) wrData = 16'($urandom_range(0, 4));
         else wrData = 16'($urandom);
         start = ($urandom_range(0, 5) == 0);
         stop = ($urandom_range(0, 19) == 0);
         RETRANSMIT = ($urandom_range(0, 4) == 0);
         step();
      end
      wrEn = 0; start = 0; RETRANSMIT = 0;

      // Asynchronous reset mid-frame
      stop = 1; pulse(1); pulse(1); stop = 0;
      start = 1; step(); start = 0;
      chk("pre_reset_en", ENABLE, 1);
      RESET = 1; #2;
      chk("async_reset_en", ENABLE, 0);
      chk("async_reset_busy", busy, 0);
      step();
      RESET = 0;
      step();
      chk("post_reset_s0", State0Value, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/doppler_sequencer.md
# doppler_sequencer

Pulse-repetition controller for the Doppler core layer. Holds a host-writable shadow bank for the four state thresholds, the transmit frequency and the pulses-per-frame count. Commits validated settings to the active outputs only at safe points: idle, or the retransmit cycle. Drives the core's ENABLE to run single frames, continuous frames, or free-running bursts with a clean stop at a pulse boundary.

## Interface
- DEF_S0, 16'd32: reset value of active State0Value
- DEF_S1, 16'd64: reset value of active State1Value
- DEF_S2, 16'd1024: reset value of active State2Value
- DEF_SR, 16'd4096: reset value of active StateRValue
- DEF_FREQ, 2'b00: reset value of active freq, in the codebase freq encoding
- coreClock  in  1  single clock, shared with the core layer
- RESET  in  1  asynchronous, active-high reset
- wrEn  in  1  host register write strobe
- wrAddr  in  3  0=S0, 1=S1, 2=S2, 3=SR, 4=pulsesPerFrame, 5=mode (bits[1:0] freq, bit2 continuous), 6=commit (data ignored), 7=no effect
- wrData  in  16  write data
- start  in  1  level, sampled each cycle; begin a frame
- stop  in  1  level, sampled each cycle; finish the current pulse, then idle
- RETRANSMIT  in  1  core's one-cycle end-of-pulse indication
- ENABLE  out  1  core enable, registered
- freq  out  2  active frequency select
- State0Value, State1Value, State2Value, StateRValue  out  16 each  active thresholds
- pulseCount  out  16  pulses completed in the current/last frame
- busy  out  1  state != IDLE
- frameDone  out  1  one-cycle pulse at frame end
- cfgPending  out  1  commit requested, not yet applied
- cfgError  out  1  sticky; last applied commit was rejected

## Operation
- Shadow registers: written on any cycle via wrEn/wrAddr. Reset values equal the DEF_* parameters; pulsesPerFrame resets to 0 and continuous to 0.
- Commit: a write to address 6 sets cfgPending. The apply point is:
  - IDLE: the next edge.
  - RUN/DRAIN/DONE: the next edge with RETRANSMIT=1.
- At the apply point, the current shadow contents are checked against the rule 0 < S0 < S1 < S2 < SR.
  - Pass: copy S0..SR, freq, continuous and N (pulsesPerFrame) to the active set, and clear cfgError.
  - Fail: the active set is unchanged and cfgError is set.
  - Either way, cfgPending clears.
- A commit write on the same edge as an apply re-arms cfgPending.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: ENABLE=0. start=1 and stop=0 → RUN, with pulseCount cleared to 0.
  - RUN: ENABLE=1. Each RETRANSMIT increments pulseCount (16-bit, wraps).
    - stop=1 → DRAIN (stop has priority over frame end).
    - N≠0 and RETRANSMIT while pulseCount==N-1 → DONE.
    - N=0: free-run until stop.
  - DRAIN: ENABLE=1. RETRANSMIT increments pulseCount → IDLE.
  - DONE: ENABLE=0 and frameDone=1, for exactly one cycle.
    - stop=1 or continuous=0 → IDLE.
    - Otherwise → RUN, with pulseCount cleared.
- start while not in IDLE has no effect. stop in IDLE has no effect.

## Timing
- Reset values:
  - Outputs: ENABLE=0, busy=0, frameDone=0, cfgPending=0, cfgError=0, pulseCount=0.
  - Active thresholds and freq: DEF_*.
  - State: IDLE.
- Asserting RESET mid-frame drops ENABLE immediately (asynchronously).
- start sampled at edge k: ENABLE=1 and busy=1 after edge k.
- Outputs are all registered, with no combinational input-to-output path.
- An apply on the RETRANSMIT edge updates the active outputs on that same edge. The next burst uses the new values.
- An apply in IDLE takes effect one edge after the commit write.
- RETRANSMIT is ignored in IDLE: no count change and no apply.
- In DONE, cfgPending is applied only if RETRANSMIT is high, which a correct core never does.

## Test plan
- Reset: defaults on all outputs. Write S0..SR = 10/20/30/40, then commit in IDLE → outputs 10/20/30/40 one edge after the commit, with cfgPending high for exactly 1 cycle.
- N=3, continuous=0, start: pulse RETRANSMIT 3 times → pulseCount=3, DONE for 1 cycle with frameDone=1 and ENABLE=0, then IDLE.
- N=2, continuous=1: 2 pulses → frameDone, ENABLE low for 1 cycle, RUN resumes with pulseCount=0. Raise stop during DONE → IDLE.
- N=0, RUN: commit S2=500 mid-pulse → State2Value unchanged until the RETRANSMIT edge, then 500. stop mid-pulse → ENABLE stays 1 until the next RETRANSMIT, then IDLE with pulseCount incremented.
- Invalid commit (S1=S0=50) → cfgError=1, active unchanged. A following valid commit → cfgError=0.
- N=1 and RETRANSMIT with stop=1 in the same cycle → DRAIN/IDLE path, frameDone stays 0. start and stop both high in IDLE → stays IDLE.
